// File: rtl/accel_pkg.sv
// Shared types and default widths for the NN accelerator address sequencer.
package accel_pkg;

  localparam int ACCEL_ADDR_W = 16;
  localparam int ACCEL_CNT_W  = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/accel_beat_counter.sv
// Loadable up-counter that wraps to zero after reaching limit-1 and flags its last value.
module accel_beat_counter
  import accel_pkg::*;
#(
  parameter int CNT_W = ACCEL_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             inc,
  input  logic [CNT_W-1:0] limit,
  output logic [CNT_W-1:0] count,
  output logic             at_last
);

  logic [CNT_W-1:0] count_r;

  assign count   = count_r;
  assign at_last = (count_r == (limit - CNT_W'(1)));

  // Counter register: load clears, increment wraps after the last value.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_r <= '0;
    end else if (load) begin
      count_r <= '0;
    end else if (inc) begin
      if (at_last) begin
        count_r <= '0;
      end else begin
        count_r <= count_r + CNT_W'(1);
      end
    end else begin
      count_r <= count_r;
    end
  end

endmodule

// File: rtl/accelerator_fsm.sv
// Address-sequencing controller: walks weight/input memories for one fully-connected layer.
module accelerator_fsm
  import accel_pkg::*;
#(
  parameter int ADDR_W = ACCEL_ADDR_W,
  parameter int CNT_W  = ACCEL_CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] BaseAddr_W,
  input  logic [ADDR_W-1:0] BaseAddr_in,
  input  logic [CNT_W-1:0]  total_output_neurons,
  input  logic [CNT_W-1:0]  total_input_neurons,
  input  logic              DVAL,
  input  logic              accelerator_start,
  input  logic              Enable,
  output logic [ADDR_W-1:0] Waddress_current,
  output logic [ADDR_W-1:0] Inaddress_current,
  output logic              neuron_done
);

  state_e             state_r;
  state_e             next_state_s;
  logic               load_s;
  logic               beat_s;
  logic               zero_len_s;
  logic               in_last_s;
  logic               out_last_s;
  logic [CNT_W-1:0]   in_cnt_s;
  logic [CNT_W-1:0]   out_cnt_s;
  logic [ADDR_W-1:0]  waddr_r;
  logic [ADDR_W-1:0]  inaddr_r;
  logic               neuron_done_r;

  assign beat_s     = Enable && DVAL && (state_r == RUN);
  assign zero_len_s = (total_input_neurons == '0) || (total_output_neurons == '0);

  accel_beat_counter #(.CNT_W(CNT_W)) u_in_cnt (
    .clk     (clk),
    .rst     (rst),
    .load    (load_s),
    .inc     (beat_s),
    .limit   (total_input_neurons),
    .count   (in_cnt_s),
    .at_last (in_last_s)
  );

  accel_beat_counter #(.CNT_W(CNT_W)) u_out_cnt (
    .clk     (clk),
    .rst     (rst),
    .load    (load_s),
    .inc     (beat_s && in_last_s),
    .limit   (total_output_neurons),
    .count   (out_cnt_s),
    .at_last (out_last_s)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state and load decode; Enable low freezes everything.
  always_comb begin
    next_state_s = state_r;
    load_s       = 1'b0;
    if (Enable) begin
      case (state_r)
        IDLE: begin
          if (accelerator_start) begin
            load_s       = 1'b1;
            next_state_s = zero_len_s ? DONE : RUN;
          end else begin
            next_state_s = IDLE;
          end
        end
        RUN: begin
          if (beat_s && in_last_s && out_last_s) begin
            next_state_s = DONE;
          end else begin
            next_state_s = RUN;
          end
        end
        DONE: begin
          if (!accelerator_start) begin
            next_state_s = IDLE;
          end else begin
            next_state_s = DONE;
          end
        end
        default: begin
          next_state_s = IDLE;
        end
      endcase
    end else begin
      next_state_s = state_r;
    end
  end

  // Address registers: weight address is linear, input address rewinds per neuron.
  always_ff @(posedge clk) begin
    if (rst) begin
      waddr_r       <= '0;
      inaddr_r      <= '0;
      neuron_done_r <= 1'b0;
    end else if (load_s) begin
      waddr_r       <= BaseAddr_W;
      inaddr_r      <= BaseAddr_in;
      neuron_done_r <= 1'b0;
    end else if (beat_s) begin
      waddr_r       <= waddr_r + ADDR_W'(1);
      inaddr_r      <= in_last_s ? BaseAddr_in : (inaddr_r + ADDR_W'(1));
      neuron_done_r <= in_last_s;
    end else begin
      waddr_r       <= waddr_r;
      inaddr_r      <= inaddr_r;
      neuron_done_r <= 1'b0;
    end
  end

  assign Waddress_current  = waddr_r;
  assign Inaddress_current = inaddr_r;
  assign neuron_done       = neuron_done_r;

endmodule

// File: tb/tb_accelerator_fsm.sv
// Scoreboard bench for accelerator_fsm: a behavioural model pushes expectations, DUT output pops them.
module tb_accelerator_fsm;
  import accel_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] BaseAddr_W = 16'h1111;
  logic [15:0] BaseAddr_in = 16'h0000;
  logic [15:0] total_output_neurons = 16'h0010;
  logic [15:0] total_input_neurons = 16'h0020;
  logic        DVAL = 1'b0;
  logic        accelerator_start = 1'b0;
  logic        Enable = 1'b0;
  logic [15:0] Waddress_current;
  logic [15:0] Inaddress_current;
  logic        neuron_done;

  accelerator_fsm dut (
    .clk                  (clk),
    .rst                  (rst),
    .BaseAddr_W           (BaseAddr_W),
    .BaseAddr_in          (BaseAddr_in),
    .total_output_neurons (total_output_neurons),
    .total_input_neurons  (total_input_neurons),
    .DVAL                 (DVAL),
    .accelerator_start    (accelerator_start),
    .Enable               (Enable),
    .Waddress_current     (Waddress_current),
    .Inaddress_current    (Inaddress_current),
    .neuron_done          (neuron_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] w;
    logic [15:0] in;
    logic        done;
    logic [1:0]  st;
  } exp_t;

  exp_t        sb_q[$];
  int          checks = 0;
  int          errors = 0;
  int          pulses = 0;
  state_e      m_state = IDLE;
  logic [15:0] m_w = 16'h0000;
  logic [15:0] m_in = 16'h0000;
  logic [15:0] m_ic = 16'h0000;
  logic [15:0] m_oc = 16'h0000;

  // One clock: drive inputs, model the expected result, then compare after the edge.
  task automatic step(input logic r, input logic s, input logic e, input logic d);
    exp_t       ex;
    logic       m_done;
    logic [1:0] st_obs;
    @(negedge clk);
    rst = r; accelerator_start = s; Enable = e; DVAL = d;
    m_done = 1'b0;
    if (r) begin
      m_state = IDLE; m_w = 16'h0000; m_in = 16'h0000; m_ic = 16'h0000; m_oc = 16'h0000;
    end else if (e) begin
      case (m_state)
        IDLE: if (s) begin
          m_w = BaseAddr_W; m_in = BaseAddr_in; m_ic = 16'h0000; m_oc = 16'h0000;
          m_state = (total_input_neurons == 16'h0000 || total_output_neurons == 16'h0000) ? DONE : RUN;
        end
        RUN: if (d) begin
          m_w = m_w + 16'h0001;
          if (m_ic == total_input_neurons - 16'h0001) begin
            m_in = BaseAddr_in; m_ic = 16'h0000; m_done = 1'b1;
            if (m_oc == total_output_neurons - 16'h0001) m_state = DONE;
            else m_oc = m_oc + 16'h0001;
          end else begin
            m_in = m_in + 16'h0001; m_ic = m_ic + 16'h0001;
          end
        end
        DONE: if (!s) m_state = IDLE;
        default: m_state = IDLE;
      endcase
    end
    ex.w = m_w; ex.in = m_in; ex.done = m_done; ex.st = m_state;
    sb_q.push_back(ex);
    @(posedge clk);
    #1;
    ex = sb_q.pop_front();
    st_obs = dut.state_r;
    checks++;
    if (Waddress_current !== ex.w) begin
      errors++; $display("FAIL sb_waddr t=%0t got %h expected %h", $time, Waddress_current, ex.w);
    end
    checks++;
    if (Inaddress_current !== ex.in) begin
      errors++; $display("FAIL sb_inaddr t=%0t got %h expected %h", $time, Inaddress_current, ex.in);
    end
    checks++;
    if (neuron_done !== ex.done) begin
      errors++; $display("FAIL sb_done t=%0t got %b expected %b", $time, neuron_done, ex.done);
    end
    checks++;
    if (st_obs !== ex.st) begin
      errors++; $display("FAIL sb_state t=%0t got %0d expected %0d", $time, st_obs, ex.st);
    end
    if (neuron_done === 1'b1) pulses++;
  endtask

  task automatic test_reset();
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    checks++;
    if (Waddress_current !== 16'h0000 || Inaddress_current !== 16'h0000 || neuron_done !== 1'b0) begin
      errors++; $display("FAIL reset got %h/%h/%b expected 0000/0000/0", Waddress_current, Inaddress_current, neuron_done);
    end
  endtask

  task automatic test_start();
    step(1'b0, 1'b1, 1'b1, 1'b0);
    checks++;
    if (Waddress_current !== 16'h1111 || Inaddress_current !== 16'h0000 || dut.state_r !== RUN) begin
      errors++; $display("FAIL start got %h/%h expected 1111/0000 in RUN", Waddress_current, Inaddress_current);
    end
  endtask

  task automatic test_gap();
    int p0;
    p0 = pulses;
    repeat (16) step(1'b0, 1'b1, 1'b1, 1'b1);
    repeat (2) step(1'b0, 1'b1, 1'b1, 1'b0);
    checks++;
    if (Waddress_current !== 16'h1121 || Inaddress_current !== 16'h0010 || pulses != p0) begin
      errors++; $display("FAIL gap got %h/%h pulses %0d expected 1121/0010 pulses 0", Waddress_current, Inaddress_current, pulses - p0);
    end
  endtask

  task automatic test_neuron_done();
    int p0;
    p0 = pulses;
    repeat (16) step(1'b0, 1'b1, 1'b1, 1'b1);
    checks++;
    if (pulses - p0 != 1 || neuron_done !== 1'b1 || Inaddress_current !== 16'h0000 || Waddress_current !== 16'h1131) begin
      errors++; $display("FAIL neuron_done got pulses %0d addr %h/%h expected 1 at 1131/0000", pulses - p0, Waddress_current, Inaddress_current);
    end
  endtask

  task automatic test_freeze();
    int p0;
    p0 = pulses;
    repeat (5) step(1'b0, 1'b1, 1'b0, 1'b1);
    checks++;
    if (Waddress_current !== 16'h1131 || Inaddress_current !== 16'h0000 || pulses != p0 || dut.u_in_cnt.count !== 16'h0000) begin
      errors++; $display("FAIL freeze got %h/%h pulses %0d expected 1131/0000 pulses 0", Waddress_current, Inaddress_current, pulses - p0);
    end
  endtask

  task automatic test_full_layer();
    repeat (480) step(1'b0, 1'b1, 1'b1, 1'b1);
    checks++;
    if (pulses != 16 || dut.state_r !== DONE || Waddress_current !== 16'h1311 || Inaddress_current !== 16'h0000) begin
      errors++; $display("FAIL full_layer got pulses %0d addr %h/%h expected 16 at 1311/0000 DONE", pulses, Waddress_current, Inaddress_current);
    end
    repeat (3) step(1'b0, 1'b1, 1'b1, 1'b1);
    checks++;
    if (Waddress_current !== 16'h1311 || pulses != 16) begin
      errors++; $display("FAIL done_hold got %h pulses %0d expected 1311 pulses 16", Waddress_current, pulses);
    end
  endtask

  task automatic test_return_idle();
    step(1'b0, 1'b0, 1'b1, 1'b0);
    checks++;
    if (dut.state_r !== IDLE || Waddress_current !== 16'h1311) begin
      errors++; $display("FAIL return_idle got state %0d addr %h expected IDLE 1311", dut.state_r, Waddress_current);
    end
  endtask

  task automatic test_zero_inputs();
    int p0;
    p0 = pulses;
    total_input_neurons = 16'h0000;
    step(1'b0, 1'b1, 1'b1, 1'b0);
    checks++;
    if (dut.state_r !== DONE) begin
      errors++; $display("FAIL zero_inputs got state %0d expected DONE", dut.state_r);
    end
    repeat (3) step(1'b0, 1'b1, 1'b1, 1'b1);
    checks++;
    if (Waddress_current !== 16'h1111 || pulses != p0) begin
      errors++; $display("FAIL zero_beats got %h pulses %0d expected 1111 pulses 0", Waddress_current, pulses - p0);
    end
    step(1'b0, 1'b0, 1'b1, 1'b0);
    total_input_neurons = 16'h0020;
  endtask

  task automatic test_mid_run_reset();
    step(1'b0, 1'b1, 1'b1, 1'b0);
    repeat (5) step(1'b0, 1'b1, 1'b1, 1'b1);
    checks++;
    if (Waddress_current !== 16'h1116 || Inaddress_current !== 16'h0005) begin
      errors++; $display("FAIL pre_reset got %h/%h expected 1116/0005", Waddress_current, Inaddress_current);
    end
    step(1'b1, 1'b1, 1'b1, 1'b1);
    checks++;
    if (Waddress_current !== 16'h0000 || Inaddress_current !== 16'h0000 || dut.state_r !== IDLE) begin
      errors++; $display("FAIL mid_reset got %h/%h state %0d expected 0000/0000 IDLE", Waddress_current, Inaddress_current, dut.state_r);
    end
    step(1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_back_to_back();
    int p0;
    BaseAddr_W = 16'hFFFE; BaseAddr_in = 16'h8000;
    total_input_neurons = 16'h0002; total_output_neurons = 16'h0003;
    p0 = pulses;
    step(1'b0, 1'b1, 1'b1, 1'b0);
    checks++;
    if (Waddress_current !== 16'hFFFE || Inaddress_current !== 16'h8000) begin
      errors++; $display("FAIL restart got %h/%h expected FFFE/8000", Waddress_current, Inaddress_current);
    end
    step(1'b0, 1'b1, 1'b1, 1'b1);
    checks++;
    if (Inaddress_current !== 16'h8001 || Waddress_current !== 16'hFFFF) begin
      errors++; $display("FAIL first_beat got %h/%h expected FFFF/8001", Waddress_current, Inaddress_current);
    end
    repeat (5) step(1'b0, 1'b1, 1'b1, 1'b1);
    checks++;
    if (Waddress_current !== 16'h0004 || Inaddress_current !== 16'h8000 || pulses - p0 != 3 || dut.state_r !== DONE) begin
      errors++; $display("FAIL wrap got %h/%h pulses %0d expected 0004/8000 pulses 3 DONE", Waddress_current, Inaddress_current, pulses - p0);
    end
  endtask

  initial begin
    test_reset();
    test_start();
    test_gap();
    test_neuron_done();
    test_freeze();
    test_full_layer();
    test_return_idle();
    test_zero_inputs();
    test_mid_run_reset();
    test_back_to_back();
    checks++;
    if (sb_q.size() != 0) begin
      errors++; $display("FAIL scoreboard_drain got %0d entries expected 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
